stack_seq: RTL

//  Interrupt-entry / RTI stack sequencer for the 6502 core; the consumer side of the register file.

---
 rtl/stack_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stack_seq.sv
// Interrupt-entry / RTI stack sequencer for the 6502 core: pushes PCH/PCL/SR and fetches
// the vector on entry, pulls SR/PCL/PCH on RTI, then loads SP/SR/PC through the register file.
module stack_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        RDY,
  input  logic        int_req,
  input  logic        int_nmi,
  input  logic        int_brk,
  input  logic        rti_req,
  input  logic [15:0] PC_Q,
  input  logic [7:0]  SR_Q,
  input  logic [7:0]  SP_Q,
  input  logic [7:0]  MEM_DI,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output logic        MEM_WE,
  output logic        busy,
  output logic        done,
  output logic        SP_EN,
  output logic [7:0]  SP_D,
  output logic        SR_EN,
  output logic [7:0]  SR_D,
  output logic        PC_EN,
  output logic [15:0] PC_D,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_SR, S_VEC_LO, S_VEC_HI,
    S_PULL_SR, S_PULL_PCL, S_PULL_PCH, S_DONE
  } state_e;

  state_e      state_q;
  logic [15:0] pc_w_q;
  logic [7:0]  sr_w_q;
  logic [7:0]  sp_w_q;
  logic        nmi_q;
  logic        brk_q;
  logic        entry_q;

  logic [15:0] vec_w;
  logic [7:0]  sp_inc_w;
  logic        we_w;

  assign vec_w    = nmi_q ? VEC_NMI : VEC_IRQ;
  assign sp_inc_w = sp_w_q + 8'd1;

  // Requests are level-sampled only in IDLE with RDY=1 (int_req wins); completion is the
  // done pulse in DONE, coincident with the SP/SR/PC load enables. RDY=0 freezes everything.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_w_q  <= 16'h0000;
      sr_w_q  <= 8'h00;
      sp_w_q  <= 8'h00;
      nmi_q   <= 1'b0;
      brk_q   <= 1'b0;
      entry_q <= 1'b0;
    end else if (RDY) begin
      case (state_q)
        S_IDLE: begin
          pc_w_q <= PC_Q;
          sr_w_q <= SR_Q;
          sp_w_q <= SP_Q;
          if (int_req) begin
            nmi_q   <= int_nmi;
            brk_q   <= int_brk;
            entry_q <= 1'b1;
            state_q <= S_PUSH_PCH;
          end else if (rti_req) begin
            entry_q <= 1'b0;
            state_q <= S_PULL_SR;
          end
        end
        S_PUSH_PCH: begin
          sp_w_q  <= sp_w_q - 8'd1;
          state_q <= S_PUSH_PCL;
        end
        S_PUSH_PCL: begin
          sp_w_q  <= sp_w_q - 8'd1;
          state_q <= S_PUSH_SR;
        end
        S_PUSH_SR: begin
          sp_w_q  <= sp_w_q - 8'd1;
          state_q <= S_VEC_LO;
        end
        S_VEC_LO: begin
          pc_w_q[7:0] <= MEM_DI;
          state_q     <= S_VEC_HI;
        end
        S_VEC_HI: begin
          pc_w_q[15:8] <= MEM_DI;
          state_q      <= S_DONE;
        end
        S_PULL_SR: begin
          sp_w_q  <= sp_inc_w;
          sr_w_q  <= {MEM_DI[7:6], 2'b10, MEM_DI[3:0]};
          state_q <= S_PULL_PCL;
        end
        S_PULL_PCL: begin
          sp_w_q      <= sp_inc_w;
          pc_w_q[7:0] <= MEM_DI;
          state_q     <= S_PULL_PCH;
        end
        S_PULL_PCH: begin
          sp_w_q       <= sp_inc_w;
          pc_w_q[15:8] <= MEM_DI;
          state_q      <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus and load outputs are a pure decode of registered state and working registers.
  always_comb begin
    MEM_A  = 16'h0000;
    MEM_DO = 8'h00;
    we_w   = 1'b0;
    done   = 1'b0;
    SP_EN  = 1'b0;
    SP_D   = 8'h00;
    SR_EN  = 1'b0;
    SR_D   = 8'h00;
    PC_EN  = 1'b0;
    PC_D   = 16'h0000;
    case (state_q)
      S_PUSH_PCH: begin
        MEM_A  = {STACK_PAGE, sp_w_q};
        MEM_DO = pc_w_q[15:8];
        we_w   = 1'b1;
      end
      S_PUSH_PCL: begin
        MEM_A  = {STACK_PAGE, sp_w_q};
        MEM_DO = pc_w_q[7:0];
        we_w   = 1'b1;
      end
      S_PUSH_SR: begin
        MEM_A  = {STACK_PAGE, sp_w_q};
        MEM_DO = {sr_w_q[7:6], 1'b1, brk_q, sr_w_q[3:0]};
        we_w   = 1'b1;
      end
      S_VEC_LO: MEM_A = vec_w;
      S_VEC_HI: MEM_A = vec_w + 16'd1;
      S_PULL_SR, S_PULL_PCL, S_PULL_PCH: MEM_A = {STACK_PAGE, sp_inc_w};
      S_DONE: begin
        done  = 1'b1;
        SP_EN = 1'b1;
        SP_D  = sp_w_q;
        SR_EN = 1'b1;
        SR_D  = entry_q ? (sr_w_q | 8'h04) : sr_w_q;
        PC_EN = 1'b1;
        PC_D  = pc_w_q;
      end
      default: ;
    endcase
  end

  assign MEM_WE      = we_w & RDY;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
